// File: rtl/sim_end_checker.sv
// End-of-test monitor: counts RUN cycles, watches for the end code in the end-flag word,
// then walks the result region comparing each word against a golden store.
module sim_end_checker #(
    parameter int          ADDR_W          = 16,
    parameter int          SIM_END_WORD    = 'h3fff,
    parameter logic [31:0] END_CODE        = 32'hffffffff,
    parameter int          TEST_START_WORD = 'h2000,
    parameter int          NUM_WORDS       = 64,
    parameter int          MAX_CYCLES      = 150000,
    parameter int          CNT_W           = 32,
    parameter int          ERR_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        data_write,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_in,
    output logic              chk_read,
    output logic [ADDR_W-3:0] chk_addr,
    input  logic [31:0]       chk_data,
    output logic [ADDR_W-3:0] gold_addr,
    input  logic [31:0]       gold_data,
    output logic              mis_valid,
    output logic [ADDR_W-3:0] mis_idx,
    output logic [31:0]       mis_got,
    output logic [31:0]       mis_exp,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [2:0]        dbg_state
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0] END_IDX   = IDX_W'(SIM_END_WORD);
    localparam logic [IDX_W-1:0] START_IDX = IDX_W'(TEST_START_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'((NUM_WORDS > 0) ? NUM_WORDS - 1 : 0);
    localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_SCAN  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_TOUT  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [31:0]      merged;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] pidx_q;
    logic             pv_q, pv_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             tout_q, tout_d;
    logic             snoop_hit;
    logic             end_hit;
    logic             mismatch;

    // End word as it would look after this cycle's byte-enabled write.
    always_comb begin
        merged = shadow_q;
        for (int k = 0; k < 4; k++) begin
            if (data_write[k]) merged[8*k +: 8] = data_in[8*k +: 8];
        end
    end

    assign snoop_hit = (data_write != 4'b0000) && (data_addr[ADDR_W-1:2] == END_IDX);
    assign end_hit   = snoop_hit && (merged == END_CODE);
    // pv_q marks a cycle whose memory/golden read data belongs to the index in pidx_q.
    assign mismatch  = pv_q && (chk_data != gold_data);

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        pv_d     = 1'b0;
        cycle_d  = cycle_q;
        err_d    = err_q;
        done_d   = done_q;
        pass_d   = pass_q;
        tout_d   = tout_q;
        if (mismatch && (err_q != '1)) err_d = err_q + 1'b1;
        case (state_q)
            ST_RUN: begin
                if (cycle_q != '1) cycle_d = cycle_q + 1'b1;
                if (snoop_hit) shadow_d = merged;
                if (end_hit) begin
                    if (NUM_WORDS == 0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = ST_SCAN;
                        idx_d   = '0;
                    end
                end else if (cycle_q == CYC_LAST) begin
                    state_d = ST_TOUT;
                    tout_d  = 1'b1;
                    done_d  = 1'b1;
                end
            end
            ST_SCAN: begin
                pv_d = 1'b1;
                if (idx_q == LAST_IDX) state_d = ST_DRAIN;
                else idx_d = idx_q + 1'b1;
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                pass_d  = (err_d == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            shadow_q <= '0;
            idx_q    <= '0;
            pidx_q   <= '0;
            pv_q     <= 1'b0;
            cycle_q  <= '0;
            err_q    <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            pidx_q   <= idx_q;
            pv_q     <= pv_d;
            cycle_q  <= cycle_d;
            err_q    <= err_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            tout_q   <= tout_d;
        end
    end

    assign chk_read  = (state_q == ST_SCAN);
    assign chk_addr  = chk_read ? (START_IDX + idx_q) : '0;
    assign gold_addr = chk_read ? idx_q : '0;
    assign mis_valid = mismatch;
    assign mis_idx   = mismatch ? pidx_q : '0;
    assign mis_got   = mismatch ? chk_data : '0;
    assign mis_exp   = mismatch ? gold_data : '0;
    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = tout_q;
    assign err_cnt   = err_q;
    assign cycle_cnt = cycle_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sim_end_checker.sv
// Directed bench for sim_end_checker: three instances cover the default run length,
// a short timeout limit and an empty result region.
module tb_sim_end_checker;

    localparam logic [2:0] S_RUN  = 3'd0;
    localparam logic [2:0] S_SCAN = 3'd1;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_TOUT = 3'd4;

    logic        clk;
    logic        rst_a, rst_b, rst_c;
    logic [3:0]  data_write;
    logic [31:0] data_addr;
    logic [31:0] data_in;

    logic        chk_read_a, chk_read_b, chk_read_c;
    logic [13:0] chk_addr_a, chk_addr_b, chk_addr_c;
    logic [13:0] gold_addr_a, gold_addr_b, gold_addr_c;
    logic [31:0] chk_data_a, chk_data_b, gold_data_a, gold_data_b;
    logic [31:0] chk_data_c, gold_data_c;
    logic        mis_valid_a, mis_valid_b, mis_valid_c;
    logic [13:0] mis_idx_a, mis_idx_b, mis_idx_c;
    logic [31:0] mis_got_a, mis_got_b, mis_got_c;
    logic [31:0] mis_exp_a, mis_exp_b, mis_exp_c;
    logic        done_a, done_b, done_c;
    logic        pass_a, pass_b, pass_c;
    logic        tout_a, tout_b, tout_c;
    logic [15:0] err_a, err_b, err_c;
    logic [31:0] cyc_a, cyc_b, cyc_c;
    logic [2:0]  st_a, st_b, st_c;

    logic [31:0] mem[4];
    logic [31:0] gold[4];

    int checks;
    int errors;
    int mis_cnt_a;
    int rd_cnt_a;
    int rd_cnt_b;
    logic [13:0] last_idx_a;
    logic [31:0] last_got_a, last_exp_a;

    typedef struct {
        logic [3:0]  we;
        logic [13:0] word;
        logic [31:0] data;
        logic [2:0]  exp_state;
    } vec_t;
    vec_t vecs[6];

    sim_end_checker #(.NUM_WORDS(4)) dut_a (
        .clk(clk), .rst(rst_a), .data_write(data_write), .data_addr(data_addr), .data_in(data_in),
        .chk_read(chk_read_a), .chk_addr(chk_addr_a), .chk_data(chk_data_a),
        .gold_addr(gold_addr_a), .gold_data(gold_data_a),
        .mis_valid(mis_valid_a), .mis_idx(mis_idx_a), .mis_got(mis_got_a), .mis_exp(mis_exp_a),
        .done(done_a), .pass(pass_a), .timeout(tout_a), .err_cnt(err_a), .cycle_cnt(cyc_a),
        .dbg_state(st_a));

    sim_end_checker #(.NUM_WORDS(4), .MAX_CYCLES(50)) dut_b (
        .clk(clk), .rst(rst_b), .data_write(data_write), .data_addr(data_addr), .data_in(data_in),
        .chk_read(chk_read_b), .chk_addr(chk_addr_b), .chk_data(chk_data_b),
        .gold_addr(gold_addr_b), .gold_data(gold_data_b),
        .mis_valid(mis_valid_b), .mis_idx(mis_idx_b), .mis_got(mis_got_b), .mis_exp(mis_exp_b),
        .done(done_b), .pass(pass_b), .timeout(tout_b), .err_cnt(err_b), .cycle_cnt(cyc_b),
        .dbg_state(st_b));

    sim_end_checker #(.NUM_WORDS(0), .MAX_CYCLES(50)) dut_c (
        .clk(clk), .rst(rst_c), .data_write(data_write), .data_addr(data_addr), .data_in(data_in),
        .chk_read(chk_read_c), .chk_addr(chk_addr_c), .chk_data(chk_data_c),
        .gold_addr(gold_addr_c), .gold_data(gold_data_c),
        .mis_valid(mis_valid_c), .mis_idx(mis_idx_c), .mis_got(mis_got_c), .mis_exp(mis_exp_c),
        .done(done_c), .pass(pass_c), .timeout(tout_c), .err_cnt(err_c), .cycle_cnt(cyc_c),
        .dbg_state(st_c));

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory and golden store: one-cycle registered read, region offset = low two index bits.
    always @(posedge clk) begin
        if (chk_read_a) begin
            chk_data_a  <= mem[chk_addr_a[1:0]];
            gold_data_a <= gold[gold_addr_a[1:0]];
        end
        if (chk_read_b) begin
            chk_data_b  <= mem[chk_addr_b[1:0]];
            gold_data_b <= gold[gold_addr_b[1:0]];
        end
    end
    assign chk_data_c  = 32'h0;
    assign gold_data_c = 32'h0;

    always @(negedge clk) begin
        if (chk_read_a) rd_cnt_a++;
        if (chk_read_b) rd_cnt_b++;
        if (mis_valid_a) begin
            mis_cnt_a++;
            last_idx_a = mis_idx_a;
            last_got_a = mis_got_a;
            last_exp_a = mis_exp_a;
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_idle();
        data_write = 4'b0000;
        data_addr  = 32'h0;
        data_in    = 32'h0;
    endtask

    task automatic drive_write(input logic [3:0] we, input logic [13:0] word, input logic [31:0] d);
        data_write = we;
        data_addr  = {16'h0, word, 2'b00};
        data_in    = d;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int base_mis, base_rd;

    initial begin
        checks = 0; errors = 0; mis_cnt_a = 0; rd_cnt_a = 0; rd_cnt_b = 0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            gold[i] = 32'hc0de_0000 + i;
            mem[i]  = 32'hc0de_0000 + i;
        end
        vecs[0] = '{4'b1111, 14'h3ffe, 32'hffffffff, S_RUN};
        vecs[1] = '{4'b0001, 14'h3fff, 32'h000000ff, S_RUN};
        vecs[2] = '{4'b0010, 14'h3fff, 32'h0000ff00, S_RUN};
        vecs[3] = '{4'b0000, 14'h3fff, 32'hffffffff, S_RUN};
        vecs[4] = '{4'b0100, 14'h3fff, 32'h00ff0000, S_RUN};
        vecs[5] = '{4'b1000, 14'h3fff, 32'hff000000, S_SCAN};
        ticks(2);

        // Reset state
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_timeout", tout_a, 0);
        check("rst_err", err_a, 0);
        check("rst_cycle", cyc_a, 0);
        check("rst_chk_read", chk_read_a, 0);
        check("rst_state", st_a, S_RUN);

        // Full-word end at RUN cycle 100, memory equals golden
        rst_a = 1'b1;
        base_rd = rd_cnt_a; base_mis = mis_cnt_a;
        ticks(99);
        check("t1_cycle99", cyc_a, 99);
        drive_write(4'b1111, 14'h3fff, 32'hffffffff);
        tick();
        drive_idle();
        check("t1_state_scan", st_a, S_SCAN);
        check("t1_cycle_end", cyc_a, 100);
        ticks(4);
        check("t1_done_early", done_a, 0);
        tick();
        check("t1_done", done_a, 1);
        check("t1_pass", pass_a, 1);
        check("t1_err", err_a, 0);
        check("t1_cycle_frozen", cyc_a, 100);
        check("t1_reads", rd_cnt_a - base_rd, 4);
        check("t1_no_mis", mis_cnt_a - base_mis, 0);

        // Byte-wise end with one corrupted region word
        rst_a = 1'b0;
        mem[2] = 32'h12345678;
        gold[2] = 32'h87654321;
        tick();
        rst_a = 1'b1;
        base_mis = mis_cnt_a;
        ticks(3);
        for (int i = 0; i < 6; i++) begin
            drive_write(vecs[i].we, vecs[i].word, vecs[i].data);
            tick();
            check($sformatf("t2_vec%0d_state", i), st_a, vecs[i].exp_state);
        end
        drive_idle();
        check("t2_cycle", cyc_a, 9);
        ticks(5);
        check("t2_done", done_a, 1);
        check("t2_pass", pass_a, 0);
        check("t2_err", err_a, 1);
        check("t2_mis_count", mis_cnt_a - base_mis, 1);
        check("t2_mis_idx", last_idx_a, 2);
        check("t2_mis_got", last_got_a, 32'h12345678);
        check("t2_mis_exp", last_exp_a, 32'h87654321);
        drive_write(4'b1111, 14'h3fff, 32'hffffffff);
        ticks(3);
        drive_idle();
        check("t2_state_hold", st_a, S_DONE);
        check("t2_cycle_hold", cyc_a, 9);

        // Reset mid-SCAN, then a clean rerun
        gold[2] = 32'hc0de_0002;
        mem[2]  = 32'hc0de_0002;
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        ticks(2);
        drive_write(4'b1111, 14'h3fff, 32'hffffffff);
        tick();
        drive_idle();
        ticks(2);
        check("t5_in_scan", st_a, S_SCAN);
        rst_a = 1'b0;
        #1;
        check("t5_async_state", st_a, S_RUN);
        check("t5_async_chk_read", chk_read_a, 0);
        check("t5_async_cycle", cyc_a, 0);
        check("t5_async_done", done_a, 0);
        check("t5_async_mis", mis_valid_a, 0);
        check("t5_async_addr", chk_addr_a, 0);
        tick();
        rst_a = 1'b1;
        ticks(10);
        drive_write(4'b1111, 14'h3fff, 32'hffffffff);
        tick();
        drive_idle();
        ticks(5);
        check("t5_done", done_a, 1);
        check("t5_pass", pass_a, 1);
        check("t5_err", err_a, 0);
        check("t5_cycle", cyc_a, 11);
        rst_a = 1'b0;

        // Timeout with MAX_CYCLES=50
        rst_b = 1'b1;
        base_rd = rd_cnt_b;
        ticks(49);
        check("t3_pre_timeout", tout_b, 0);
        check("t3_pre_state", st_b, S_RUN);
        tick();
        check("t3_timeout", tout_b, 1);
        check("t3_done", done_b, 1);
        check("t3_pass", pass_b, 0);
        check("t3_cycle", cyc_b, 50);
        drive_write(4'b1111, 14'h3fff, 32'hffffffff);
        ticks(3);
        drive_idle();
        check("t3_state_hold", st_b, S_TOUT);
        check("t3_cycle_hold", cyc_b, 50);
        check("t3_no_reads", rd_cnt_b - base_rd, 0);

        // End write exactly on the timeout boundary: end wins
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        ticks(49);
        check("t4_cycle_boundary", cyc_b, 49);
        drive_write(4'b1111, 14'h3fff, 32'hffffffff);
        tick();
        drive_idle();
        check("t4_state_scan", st_b, S_SCAN);
        check("t4_no_timeout", tout_b, 0);
        ticks(5);
        check("t4_done", done_b, 1);
        check("t4_pass", pass_b, 1);
        check("t4_timeout_after", tout_b, 0);
        rst_b = 1'b0;

        // Empty region on the boundary: straight to DONE
        rst_c = 1'b1;
        ticks(49);
        drive_write(4'b1111, 14'h3fff, 32'hffffffff);
        tick();
        drive_idle();
        check("t6_done", done_c, 1);
        check("t6_pass", pass_c, 1);
        check("t6_timeout", tout_c, 0);
        check("t6_cycle", cyc_c, 50);
        check("t6_state", st_c, S_DONE);
        ticks(2);
        check("t6_chk_read", chk_read_c, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
